// File: rtl/acc_alu_seq.sv
// Execute unit feeding the accumulator: single-cycle ALU ops plus an optional
// iterative shift-add multiplier, enabled by defining ACC_ALU_MUL_EN.
module acc_alu_seq #(
  parameter int unsigned NBITS_D  = 16,
  parameter int unsigned NBITS_OP = 3
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NBITS_OP-1:0] i_op,
  input  logic [NBITS_D-1:0]  i_A,
  input  logic [NBITS_D-1:0]  i_B,
  output logic                o_ready,
  output logic [NBITS_D-1:0]  o_result,
  output logic                o_WrAcc,
  output logic                o_carry
);

  localparam int unsigned ShW  = $clog2(NBITS_D);
  localparam int unsigned CntW = ShW + 1;

  localparam logic [NBITS_OP-1:0] OpAdd = NBITS_OP'(0);
  localparam logic [NBITS_OP-1:0] OpSub = NBITS_OP'(1);
  localparam logic [NBITS_OP-1:0] OpAnd = NBITS_OP'(2);
  localparam logic [NBITS_OP-1:0] OpOr  = NBITS_OP'(3);
  localparam logic [NBITS_OP-1:0] OpXor = NBITS_OP'(4);
  localparam logic [NBITS_OP-1:0] OpShl = NBITS_OP'(5);
  localparam logic [NBITS_OP-1:0] OpShr = NBITS_OP'(6);
  localparam logic [NBITS_OP-1:0] OpMul = NBITS_OP'(7);

  logic [NBITS_D:0]   sum_ext;
  logic [NBITS_D:0]   diff_ext;
  logic [ShW-1:0]     shamt;
  logic [NBITS_D-1:0] alu_res;
  logic               alu_carry;
  logic               alu_issue;
  logic               mul_done;
  logic [NBITS_D-1:0] mul_res;

  logic [NBITS_D-1:0] result_q;
  logic               carry_q;
  logic               wr_q;

  // Single-cycle datapath; opcode 111 yields zero when no multiplier is built.
  always_comb begin
    sum_ext   = {1'b0, i_A} + {1'b0, i_B};
    diff_ext  = {1'b0, i_A} - {1'b0, i_B};
    shamt     = i_B[ShW-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    case (i_op)
      OpAdd: begin
        alu_res   = sum_ext[NBITS_D-1:0];
        alu_carry = sum_ext[NBITS_D];
      end
      OpSub: begin
        alu_res   = diff_ext[NBITS_D-1:0];
        alu_carry = diff_ext[NBITS_D];
      end
      OpAnd:   alu_res = i_A & i_B;
      OpOr:    alu_res = i_A | i_B;
      OpXor:   alu_res = i_A ^ i_B;
      OpShl:   alu_res = i_A << shamt;
      OpShr:   alu_res = i_A >> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ACC_ALU_MUL_EN
  typedef enum logic {StIdle, StMul} state_e;

  state_e             state_q, state_d;
  logic [NBITS_D-1:0] a_q;
  logic [NBITS_D-1:0] b_q;
  logic [NBITS_D-1:0] prod_q;
  logic [CntW-1:0]    cnt_q;
  logic               is_mul;
  logic               last_step;

  assign is_mul    = (i_op == OpMul);
  assign last_step = (cnt_q == CntW'(NBITS_D - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (i_valid && is_mul) state_d = StMul;
      StMul:   if (last_step) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_ready  = (state_q == StIdle);
    mul_done = (state_q == StMul) && last_step;
  end

  assign alu_issue = i_valid && o_ready && !is_mul;
  // Final partial-product add is folded into the result write.
  assign mul_res   = prod_q + (b_q[0] ? a_q : '0);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == StIdle) begin
      if (i_valid && is_mul) begin
        a_q    <= i_A;
        b_q    <= i_B;
        prod_q <= '0;
        cnt_q  <= '0;
      end
    end else begin
      a_q    <= a_q << 1;
      b_q    <= b_q >> 1;
      prod_q <= mul_res;
      cnt_q  <= cnt_q + CntW'(1);
    end
  end
`else
  assign o_ready   = 1'b1;
  assign alu_issue = i_valid;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      wr_q     <= 1'b0;
    end else if (alu_issue) begin
      result_q <= alu_res;
      carry_q  <= alu_carry;
      wr_q     <= 1'b1;
    end else if (mul_done) begin
      result_q <= mul_res;
      carry_q  <= 1'b0;
      wr_q     <= 1'b1;
    end else begin
      wr_q     <= 1'b0;
    end
  end

  assign o_result = result_q;
  assign o_carry  = carry_q;
  assign o_WrAcc  = wr_q;

endmodule

// File: tb/tb_acc_alu_seq.sv
// Self-checking bench for acc_alu_seq: vector table, random ops against an
// arithmetic reference model, and hand-written multiply/reset sequences.
module tb_acc_alu_seq;

  localparam int unsigned W = 16;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_valid = 1'b0;
  logic [2:0]    i_op    = '0;
  logic [W-1:0]  i_A     = '0;
  logic [W-1:0]  i_B     = '0;
  logic          o_ready;
  logic [W-1:0]  o_result;
  logic          o_WrAcc;
  logic          o_carry;

  int n_checks = 0;
  int n_pass   = 0;

  acc_alu_seq #(.NBITS_D(W), .NBITS_OP(3)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_op    (i_op),
    .i_A     (i_A),
    .i_B     (i_B),
    .o_ready (o_ready),
    .o_result(o_result),
    .o_WrAcc (o_WrAcc),
    .o_carry (o_carry)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_carry;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // Reference model from the operation definitions in plain integer arithmetic.
  function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output logic [W-1:0] res,
                                 output logic carry);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned t;
    int sh = int'(b % W);
    carry = 1'b0;
    case (op)
      3'd0: begin t = ua + ub; res = W'(t % 65536); carry = (t >= 65536); end
      3'd1: begin t = ua + 65536 - ub; res = W'(t % 65536); carry = (ua < ub); end
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: res = a ^ b;
      3'd5: res = W'((ua * (64'd1 << sh)) % 65536);
      3'd6: res = W'(ua / (64'd1 << sh));
`ifdef ACC_ALU_MUL_EN
      default: res = W'((ua * ub) % 65536);
`else
      default: res = '0;
`endif
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge i_clock);
    i_valid = 1'b1;
    i_op    = op;
    i_A     = a;
    i_B     = b;
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    logic [W-1:0] er;
    logic         ec;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic         seen;
    int           lat;

    // Reset state
    #12;
    chk("reset_ready", o_ready, 1);
    chk("reset_result", o_result, 0);
    chk("reset_wr", o_WrAcc, 0);
    chk("reset_carry", o_carry, 0);
    @(negedge i_clock);
    i_reset = 1'b1;

    vecs.push_back('{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0});
    vecs.push_back('{3'd0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1});
    vecs.push_back('{3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1});
    vecs.push_back('{3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0});
    vecs.push_back('{3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0});
    vecs.push_back('{3'd3, 16'hF0F0, 16'h0FF0, 16'hFFF0, 1'b0});
    vecs.push_back('{3'd4, 16'hF0F0, 16'h0FF0, 16'hFF00, 1'b0});
    vecs.push_back('{3'd5, 16'h0001, 16'hFFFF, 16'h8000, 1'b0});
    vecs.push_back('{3'd6, 16'h8000, 16'h0004, 16'h0800, 1'b0});
    vecs.push_back('{3'd5, 16'h00FF, 16'h0010, 16'h00FF, 1'b0});
`ifndef ACC_ALU_MUL_EN
    vecs.push_back('{3'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0});
    vecs.push_back('{3'd7, 16'd5, 16'd7, 16'h0000, 1'b0});
`endif

    // Consecutive issues: also exercises back-to-back acceptance.
    foreach (vecs[i]) begin
      v = vecs[i];
      issue(v.op, v.a, v.b);
      chk($sformatf("vec%0d_result", i), o_result, v.exp_res);
      chk($sformatf("vec%0d_carry", i), o_carry, v.exp_carry);
      chk($sformatf("vec%0d_wr", i), o_WrAcc, 1);
      chk($sformatf("vec%0d_ready", i), o_ready, 1);
    end

    // Idle cycle: pulse drops, result held.
    @(posedge i_clock);
    #1;
    chk("idle_wr", o_WrAcc, 0);
    chk("idle_hold", o_result, vecs[vecs.size()-1].exp_res);

    // Random single-cycle ops
    for (int k = 0; k < 150; k++) begin
`ifdef ACC_ALU_MUL_EN
      rop = 3'($urandom_range(0, 6));
`else
      rop = 3'($urandom_range(0, 7));
`endif
      ra = W'($urandom);
      rb = W'($urandom);
      ref_op(rop, ra, rb, er, ec);
      issue(rop, ra, rb);
      chk($sformatf("rnd%0d_op%0d_result", k, rop), o_result, er);
      chk($sformatf("rnd%0d_carry", k), o_carry, ec);
      chk($sformatf("rnd%0d_wr", k), o_WrAcc, 1);
      if (k % 5 == 0) begin
        @(posedge i_clock);
        #1;
        chk($sformatf("rnd%0d_idle_wr", k), o_WrAcc, 0);
        chk($sformatf("rnd%0d_idle_hold", k), o_result, er);
      end
    end

`ifdef ACC_ALU_MUL_EN
    // MUL 300*300 with an ADD request and operand changes during busy.
    issue(3'd0, 16'h1111, 16'h0001);
    issue(3'd7, 16'd300, 16'd300);
    chk("mul_t1_ready", o_ready, 0);
    chk("mul_t1_wr", o_WrAcc, 0);
    i_valid = 1'b1;
    i_op    = 3'd0;
    i_A     = 16'h0003;
    i_B     = 16'h0004;
    seen = 1'b0;
    for (int c = 2; c <= 16; c++) begin
      @(posedge i_clock);
      #1;
      if (o_ready !== 1'b0 || o_WrAcc !== 1'b0) seen = 1'b1;
    end
    chk("mul_busy_ready_low", seen, 0);
    chk("mul_busy_result_held", o_result, 16'h1112);
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    chk("mul_done_result", o_result, 16'h5F90);
    chk("mul_done_wr", o_WrAcc, 1);
    chk("mul_done_ready", o_ready, 1);
    chk("mul_done_carry", o_carry, 0);
    @(posedge i_clock);
    #1;
    chk("mul_after_wr", o_WrAcc, 0);

    // Random multiplies, latency measured with a bounded wait.
    for (int k = 0; k < 8; k++) begin
      ra = (k == 0) ? 16'hFFFF : W'($urandom);
      rb = (k == 0) ? 16'hFFFF : W'($urandom);
      ref_op(3'd7, ra, rb, er, ec);
      issue(3'd7, ra, rb);
      lat = 1;
      while (o_WrAcc !== 1'b1 && lat < 40) begin
        @(posedge i_clock);
        #1;
        lat++;
      end
      chk($sformatf("rmul%0d_latency", k), lat, W + 1);
      chk($sformatf("rmul%0d_result", k), o_result, er);
      chk($sformatf("rmul%0d_ready", k), o_ready, 1);
    end

    // Reset in the middle of a multiply.
    issue(3'd7, 16'd300, 16'd300);
    repeat (7) @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    #1;
    chk("mulrst_result", o_result, 0);
    chk("mulrst_ready", o_ready, 1);
    chk("mulrst_wr", o_WrAcc, 0);
    @(negedge i_clock);
    i_reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 24; c++) begin
      @(posedge i_clock);
      #1;
      if (o_WrAcc !== 1'b0 || o_ready !== 1'b1) seen = 1'b1;
    end
    chk("mulrst_no_pulse", seen, 0);
    chk("mulrst_result_stays", o_result, 0);
`else
    // Opcode 111 without the multiplier: zero result at latency 1.
    issue(3'd0, 16'h00FF, 16'h0001);
    issue(3'd7, 16'd5, 16'd7);
    chk("nomul_result", o_result, 0);
    chk("nomul_wr", o_WrAcc, 1);
    chk("nomul_ready", o_ready, 1);
    @(posedge i_clock);
    #1;
    chk("nomul_after_wr", o_WrAcc, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
